// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: D = A - B mod 2^WIDTH, Bout = (A < B).
// One bit per clock, LSB first; three-state control (IDLE -> RUN -> DONE).
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] D,
  output logic             Bout
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, d_q, d_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             br_q, br_d, bout_q, bout_d, busy_q, busy_d, done_q, done_d;
  logic             dbit, br_next;

  function automatic logic diff_bit(input logic a, input logic b, input logic br);
    return a ^ b ^ br;
  endfunction

  function automatic logic borrow_bit(input logic a, input logic b, input logic br);
    return (~a & b) | (~(a ^ b) & br);
  endfunction

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
    br_d    = br_q;
    bout_d  = bout_q;
    dbit    = diff_bit(a_q[0], b_q[0], br_q);
    br_next = borrow_bit(a_q[0], b_q[0], br_q);
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = A;
          b_d     = B;
          br_d    = 1'b0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        // Operands drain from the LSB end while the result fills from the MSB end.
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        d_d   = {dbit, d_q[WIDTH-1:1]};
        br_d  = br_next;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          bout_d  = br_next;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      br_q    <= 1'b0;
      bout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
      br_q    <= br_d;
      bout_q  <= bout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign D    = d_q;
  assign Bout = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor (WIDTH=4) with hand-computed results.
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] A, B;
  logic       busy, done, Bout;
  logic [3:0] D;
  int         checks = 0;
  int         errors = 0;

  serial_subtractor #(.WIDTH(4)) dut (
    .clk(clk), .rst(rst), .start(start), .A(A), .B(B),
    .busy(busy), .done(done), .D(D), .Bout(Bout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Launch one operation and follow it to its done pulse.
  task automatic run_op(input string tag, input logic [3:0] a, input logic [3:0] b,
                        input int exp_d, input int exp_bo);
    int n;
    @(negedge clk);
    A = a; B = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; A = ~a; B = ~b;
    chk({tag, "_busy_rise"}, int'(busy), 1);
    chk({tag, "_done_low"}, int'(done), 0);
    n = 0;
    while (done !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_latency"}, n, 4);
    chk({tag, "_D"}, int'(D), exp_d);
    chk({tag, "_Bout"}, int'(Bout), exp_bo);
    chk({tag, "_busy_done"}, int'(busy), 1);
    @(posedge clk); #1;
    chk({tag, "_done_once"}, int'(done), 0);
    chk({tag, "_idle"}, int'(busy), 0);
    @(posedge clk); #1;
    chk({tag, "_D_hold"}, int'(D), exp_d);
    chk({tag, "_Bout_hold"}, int'(Bout), exp_bo);
  endtask

  initial begin
    int pulses, first_at, second_at;
    rst = 1'b0; start = 1'b0; A = '0; B = '0;
    #2 rst = 1'b1;
    #1;
    chk("rst_async_busy", int'(busy), 0);
    chk("rst_async_done", int'(done), 0);
    chk("rst_async_D", int'(D), 0);
    chk("rst_async_Bout", int'(Bout), 0);
    @(posedge clk); @(posedge clk);
    @(negedge clk) rst = 1'b0;

    run_op("r7m3", 4'd7, 4'd3, 4, 0);
    run_op("r3m7", 4'd3, 4'd7, 12, 1);
    run_op("r0m0", 4'd0, 4'd0, 0, 0);
    run_op("r15m15", 4'd15, 4'd15, 0, 0);
    run_op("r0m15", 4'd0, 4'd15, 1, 1);

    // Second start during RUN must be ignored.
    @(negedge clk);
    A = 4'd9; B = 4'd2; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    A = 4'd1; B = 4'd1; start = 1'b1;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (done === 1'b1) begin
        pulses++;
        chk("ign_D", int'(D), 7);
        chk("ign_Bout", int'(Bout), 0);
      end
    end
    chk("ign_pulses", pulses, 1);

    // Reset two cycles into RUN aborts without a done pulse.
    @(negedge clk);
    A = 4'd6; B = 4'd1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("abort_busy", int'(busy), 0);
    chk("abort_D", int'(D), 0);
    chk("abort_Bout", int'(Bout), 0);
    @(negedge clk) rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) pulses++;
    end
    chk("abort_no_done", pulses, 0);
    run_op("r10m5", 4'd10, 4'd5, 5, 0);

    // start held high for 12 edges gives back-to-back ops every 6 cycles.
    @(negedge clk);
    A = 4'd5; B = 4'd3; start = 1'b1;
    pulses = 0; first_at = -1; second_at = -1;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      if (i == 11) start = 1'b0;
      if (done === 1'b1) begin
        pulses++;
        if (first_at < 0) first_at = i;
        else if (second_at < 0) second_at = i;
        chk("b2b_D", int'(D), 2);
      end
    end
    chk("b2b_pulses", pulses, 2);
    chk("b2b_first", first_at, 4);
    chk("b2b_second", second_at, 10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 SHALL have parameter WIDTH, default 4, giving the operand and result width in bits (legal range 2..16).
REQ-002 SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous active-high reset.
REQ-004 SHALL have port start, input, 1 bit: request to start a subtraction, sampled on clk rising edge.
REQ-005 SHALL have port A, input, WIDTH bits: minuend, unsigned.
REQ-006 SHALL have port B, input, WIDTH bits: subtrahend, unsigned.
REQ-007 SHALL have port busy, output, 1 bit: operation in progress; start is ignored while high.
REQ-008 SHALL have port done, output, 1 bit: one-cycle pulse marking that D and Bout are valid.
REQ-009 SHALL have port D, output, WIDTH bits: difference A-B modulo 2^WIDTH.
REQ-010 SHALL have port Bout, output, 1 bit: borrow out, high exactly when A < B.

Function
REQ-011 SHALL implement a three-state FSM with states IDLE, RUN and DONE.
REQ-012 In IDLE, start=1 at a clk edge SHALL capture A and B into internal shift registers, clear the borrow flop and bit counter, and go to RUN.
REQ-013 In RUN, each clk edge SHALL process one bit, LSB first: d = a^b^br; br_next = (~a&b) | (~(a^b)&br).
REQ-014 Each d SHALL shift into the result register from the MSB end, so that D is LSB-aligned after WIDTH steps.
REQ-015 After exactly WIDTH RUN edges, the FSM SHALL go to DONE, with D and Bout final at that edge.
REQ-016 In DONE, done SHALL be 1 for exactly one cycle, and the next edge SHALL return the FSM to IDLE unconditionally.
REQ-017 Latency: if start is captured at edge 0, done SHALL be high between edge WIDTH and edge WIDTH+1.
REQ-018 busy SHALL be 1 in RUN and in DONE, and 0 in IDLE.
REQ-019 start SHALL be ignored in RUN and DONE, with no queuing.
REQ-020 start held high continuously SHALL launch a new operation at the first edge in IDLE after DONE.
REQ-021 D and Bout SHALL hold their last final values through IDLE until the next operation completes.
REQ-022 D and Bout MAY change during RUN and are valid only when done=1 or afterwards in IDLE.
REQ-023 A and B SHALL be sampled only at the capture edge; later changes on A or B SHALL NOT affect the result.
REQ-024 done, busy, D and Bout SHALL all be registered outputs, with no combinational path from inputs.
REQ-025 The bit counter SHALL be ceil(log2(WIDTH+1)) bits wide and SHALL NOT wrap within an operation.

Reset
REQ-026 rst=1 SHALL immediately, independent of clk, force state IDLE, busy=0, done=0, D=0, Bout=0, and clear the shift registers, borrow flop and counter.
REQ-027 rst asserted mid-RUN or in DONE SHALL abort the operation with no done pulse.
REQ-028 After rst is released, the first valid start SHALL be accepted at the next clk edge.
REQ-029 A start coincident with the edge at which rst is released SHALL be accepted only if rst is already low at that edge.

Verification (WIDTH=4)
REQ-030 A=7, B=3, start for 1 cycle -> busy rises next cycle; done pulses 4 edges after capture; D=4, Bout=0.
REQ-031 A=3, B=7 -> D=12, Bout=1; done high for exactly one cycle.
REQ-032 Corner values -> A=0, B=0 gives D=0, Bout=0; A=15, B=15 gives D=0, Bout=0; A=0, B=15 gives D=1, Bout=1.
REQ-033 A=9, B=2, then start re-pulsed with A=1, B=1 during RUN -> result D=7, Bout=0; only one done pulse; the second start is ignored.
REQ-034 rst pulsed 2 cycles into RUN -> busy=0, D=0, no done; a subsequent A=10, B=5 run gives D=5, Bout=0.
REQ-035 start held high for 12 cycles -> back-to-back operations, one done pulse every 6 cycles (RUN 4 + DONE 1 + IDLE 1).
